// File: rtl/mem_logger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_logger_pkg
// Description : Shared types and helpers for the multi-channel capture logger
//               (FSM states, capture modes, width helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_logger_pkg;

    // Logger FSM states, 2-bit encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2,
        READ = 2'd3
    } state_t;

    // Capture mode, latched when a capture starts
    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_CIRC    = 1'b1
    } mode_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Channel-select width: at least one bit even for a single channel
    function automatic int chsel_w(input int n_ch);
        return (clog2(n_ch) > 1) ? clog2(n_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sdp.sv
`default_nettype none
// ============================================================================
// Module      : bram_sdp
// Description : Simple dual-port RAM, one write port and one read port with
//               a registered output (1-cycle read latency). The output
//               register holds when not reading and clears on reset; the
//               array itself is never cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_sdp
    import mem_logger_pkg::*;
#(
    parameter int NB_DATA = 16,
    parameter int NB_ADDR = 15
)(
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_re,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    localparam int c_DEPTH = 2**NB_ADDR;

    logic [NB_DATA-1:0] r_mem [c_DEPTH];
    logic [NB_DATA-1:0] r_rdata;

    // Write port: no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port, holds its value while not reading
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_logger_mc.sv
`default_nettype none
// ============================================================================
// Module      : mem_logger_mc
// Description : Multi-channel capture logger. Stores N_CH parallel sample
//               streams with decimation, in one-shot fill or circular
//               pre/post-trigger mode; chronological readback per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_logger_mc
    import mem_logger_pkg::*;
#(
    parameter int NB_DATA  = 16,
    parameter int NB_ADDR  = 15,
    parameter int N_CH     = 2,
    parameter int NB_DECIM = 8
)(
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic [N_CH*NB_DATA-1:0]   i_data,
    input  logic                      i_valid,
    input  logic                      i_run_log,
    input  logic                      i_read_log,
    input  logic                      i_mode,
    input  logic                      i_trigger,
    input  logic [NB_DECIM-1:0]       i_decim,
    input  logic [chsel_w(N_CH)-1:0]  i_ch_sel,
    input  logic [NB_ADDR-1:0]        i_addr_log_to_mem,
    output logic                      o_mem_full,
    output logic                      o_busy,
    output logic [NB_ADDR-1:0]        o_start_addr,
    output logic [NB_DATA-1:0]        o_data_log_from_mem,
    output logic                      o_data_valid
);

    localparam int                 c_NB_CHSEL = chsel_w(N_CH);
    localparam int                 c_DEPTH    = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] c_HALF     = NB_ADDR'(c_DEPTH / 2);
    localparam logic [NB_ADDR-1:0] c_LAST     = NB_ADDR'(c_DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    mode_t                 r_mode;
    logic [NB_DECIM-1:0]   r_decim;
    logic [NB_DECIM-1:0]   r_decim_cnt;
    logic [NB_ADDR-1:0]    r_wr_ptr;
    logic [NB_ADDR-1:0]    r_post_cnt;
    logic [NB_ADDR-1:0]    w_post_cnt_nxt;
    logic [NB_ADDR-1:0]    r_start_addr;
    logic                  r_trig_seen;
    logic                  r_busy;
    logic                  r_mem_full;
    logic                  r_data_valid;
    logic [c_NB_CHSEL-1:0] r_ch_sel_q;

    logic                  w_start;
    logic                  w_store;
    logic                  w_we;
    logic                  w_trig_first;
    logic                  w_done;
    logic                  w_re;
    logic [NB_ADDR-1:0]    w_rd_addr;
    logic [c_NB_CHSEL-1:0] w_ch_sel_eff;
    logic [NB_DATA-1:0]    w_rd_data [N_CH];
    logic [NB_DATA-1:0]    w_rd_mux;

    // Capture datapath decode: store strobe, trigger detection, completion
    always_comb begin
        w_start        = i_run_log && (r_state != RUN);
        w_store        = (r_state == RUN) && i_valid && (r_decim_cnt == '0);
        // A reset at this edge must not let the in-flight sample land
        w_we           = w_store && i_rst;
        w_trig_first   = (r_state == RUN) && (r_mode == MODE_CIRC) &&
                         i_trigger && !r_trig_seen;
        w_post_cnt_nxt = r_post_cnt;
        if (w_trig_first) begin
            // The trigger-cycle sample is post sample 0 when it is stored
            w_post_cnt_nxt = w_store ? NB_ADDR'(1) : '0;
        end else if (r_trig_seen && w_store) begin
            w_post_cnt_nxt = r_post_cnt + NB_ADDR'(1);
        end
        w_done = 1'b0;
        if (r_state == RUN) begin
            if (r_mode == MODE_ONESHOT) begin
                w_done = w_store && (r_wr_ptr == c_LAST);
            end else begin
                w_done = (r_trig_seen || w_trig_first) && (w_post_cnt_nxt == c_HALF);
            end
        end
    end

    // Next-state logic; a run request wins over a read request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FULL: begin
                if (i_run_log) begin
                    w_state_nxt = RUN;
                end else if (i_read_log) begin
                    w_state_nxt = READ;
                end
            end
            RUN: begin
                if (w_done) begin
                    w_state_nxt = FULL;
                end
            end
            READ: begin
                if (i_run_log) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_mem_full <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt == RUN);
            r_mem_full <= (w_state_nxt == FULL) || (w_state_nxt == READ);
        end
    end

    // Capture counters: write pointer, decimation, post-trigger count
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_mode       <= MODE_ONESHOT;
            r_decim      <= '0;
            r_decim_cnt  <= '0;
            r_wr_ptr     <= '0;
            r_post_cnt   <= '0;
            r_trig_seen  <= 1'b0;
            r_start_addr <= '0;
        end else if (w_start) begin
            r_mode      <= mode_t'(i_mode);
            r_decim     <= i_decim;
            r_decim_cnt <= '0;
            r_wr_ptr    <= '0;
            r_post_cnt  <= '0;
            r_trig_seen <= 1'b0;
        end else if (r_state == RUN) begin
            if (i_valid) begin
                r_decim_cnt <= (r_decim_cnt == r_decim) ? '0 : r_decim_cnt + NB_DECIM'(1);
            end
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
            end
            if (w_trig_first) begin
                r_trig_seen <= 1'b1;
            end
            r_post_cnt <= w_post_cnt_nxt;
            if (w_done) begin
                // Completion is always on a store, so wr_ptr+1 is the oldest slot
                r_start_addr <= (r_mode == MODE_CIRC) ? r_wr_ptr + NB_ADDR'(1) : '0;
            end
        end
    end

    // Read address: chronological index rotated by the oldest-sample address
    always_comb begin
        w_re         = (r_state == READ);
        w_rd_addr    = r_start_addr + i_addr_log_to_mem;
        w_ch_sel_eff = (int'(i_ch_sel) < N_CH) ? i_ch_sel : '0;
    end

    // Channel select and valid follow the BRAM read by one cycle
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_ch_sel_q   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_re;
            if (w_re) begin
                r_ch_sel_q <= w_ch_sel_eff;
            end
        end
    end

    // One RAM per channel, all sharing write and read addresses
    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            bram_sdp #(
                .NB_DATA (NB_DATA),
                .NB_ADDR (NB_ADDR)
            ) u_bram (
                .clk     (clk),
                .i_rst   (i_rst),
                .i_we    (w_we),
                .i_waddr (r_wr_ptr),
                .i_wdata (i_data[g*NB_DATA +: NB_DATA]),
                .i_re    (w_re),
                .i_raddr (w_rd_addr),
                .o_rdata (w_rd_data[g])
            );
        end
    endgenerate

    // Output mux over the registered RAM outputs
    always_comb begin
        w_rd_mux = w_rd_data[0];
        for (int k = 1; k < N_CH; k++) begin
            if (int'(r_ch_sel_q) == k) begin
                w_rd_mux = w_rd_data[k];
            end
        end
    end

    assign o_mem_full          = r_mem_full;
    assign o_busy              = r_busy;
    assign o_start_addr        = r_start_addr;
    assign o_data_log_from_mem = w_rd_mux;
    assign o_data_valid        = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_logger_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_logger_mc
// Description : Self-checking bench for mem_logger_mc (DEPTH=16, 2 channels).
//               Expected read data is queued when each read address is
//               driven and popped when the DUT flags valid data.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_logger_mc;

    localparam int NB_DATA  = 16;
    localparam int NB_ADDR  = 4;
    localparam int N_CH     = 2;
    localparam int NB_DECIM = 8;
    localparam int DEPTH    = 16;

    logic                    clk = 1'b0;
    logic                    i_rst;
    logic [N_CH*NB_DATA-1:0] i_data;
    logic                    i_valid;
    logic                    i_run_log;
    logic                    i_read_log;
    logic                    i_mode;
    logic                    i_trigger;
    logic [NB_DECIM-1:0]     i_decim;
    logic [0:0]              i_ch_sel;
    logic [NB_ADDR-1:0]      i_addr_log_to_mem;
    logic                    o_mem_full;
    logic                    o_busy;
    logic [NB_ADDR-1:0]      o_start_addr;
    logic [NB_DATA-1:0]      o_data_log_from_mem;
    logic                    o_data_valid;

    int                      n_tests = 0;
    int                      n_fail  = 0;
    logic [NB_DATA-1:0]      sb_q [$];
    int                      ev [DEPTH];

    always #5 clk = ~clk;

    mem_logger_mc #(
        .NB_DATA  (NB_DATA),
        .NB_ADDR  (NB_ADDR),
        .N_CH     (N_CH),
        .NB_DECIM (NB_DECIM)
    ) u_dut (
        .clk                 (clk),
        .i_rst               (i_rst),
        .i_data              (i_data),
        .i_valid             (i_valid),
        .i_run_log           (i_run_log),
        .i_read_log          (i_read_log),
        .i_mode              (i_mode),
        .i_trigger           (i_trigger),
        .i_decim             (i_decim),
        .i_ch_sel            (i_ch_sel),
        .i_addr_log_to_mem   (i_addr_log_to_mem),
        .o_mem_full          (o_mem_full),
        .o_busy              (o_busy),
        .o_start_addr        (o_start_addr),
        .o_data_log_from_mem (o_data_log_from_mem),
        .o_data_valid        (o_data_valid)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: ch0 = v, ch1 = v + 0x100
    task automatic drive(input int v, input logic valid, input logic trig, input logic rd);
        i_data     = {NB_DATA'(v + 256), NB_DATA'(v)};
        i_valid    = valid;
        i_trigger  = trig;
        i_read_log = rd;
        @(negedge clk);
        i_valid    = 1'b0;
        i_trigger  = 1'b0;
        i_read_log = 1'b0;
    endtask

    task automatic start_run(input logic mode, input int decim);
        i_mode    = mode;
        i_decim   = NB_DECIM'(decim);
        i_run_log = 1'b1;
        @(negedge clk);
        i_run_log = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic full, input logic busy);
        check_val({tag, " full"}, 32'(o_mem_full), 32'(full));
        check_val({tag, " busy"}, 32'(o_busy), 32'(busy));
    endtask

    // Enter READ and read back every address of both channels
    task automatic read_all(input string tag, input int exp_v [DEPTH]);
        logic [NB_DATA-1:0] exp_d;
        i_read_log = 1'b1;
        @(negedge clk);
        i_read_log = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            for (int a = 0; a < DEPTH; a++) begin
                i_ch_sel          = 1'(ch);
                i_addr_log_to_mem = NB_ADDR'(a);
                sb_q.push_back(NB_DATA'(exp_v[a] + ch * 256));
                @(negedge clk);
                exp_d = sb_q.pop_front();
                if (o_data_valid !== 1'b1) begin
                    check_val($sformatf("%s valid c%0d a%0d", tag, ch, a), 32'(o_data_valid), 32'd1);
                end else begin
                    check_val($sformatf("%s data c%0d a%0d", tag, ch, a),
                              32'(o_data_log_from_mem), 32'(exp_d));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;

        i_rst = 1'b0; i_data = '0; i_valid = 1'b0; i_run_log = 1'b0; i_read_log = 1'b0;
        i_mode = 1'b0; i_trigger = 1'b0; i_decim = '0; i_ch_sel = '0; i_addr_log_to_mem = '0;
        repeat (3) @(negedge clk);
        check_status("reset", 1'b0, 1'b0);
        check_val("reset start_addr", 32'(o_start_addr), 32'd0);
        check_val("reset dvalid", 32'(o_data_valid), 32'd0);
        check_val("reset data", 32'(o_data_log_from_mem), 32'd0);
        i_rst = 1'b1;
        @(negedge clk);

        // 1: one-shot, every sample stored
        start_run(1'b0, 0);
        check_status("t1 running", 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check_status("t1 before last", 1'b0, 1'b1);
            drive(i, 1'b1, 1'b0, 1'b0);
        end
        check_status("t1 done", 1'b1, 1'b0);
        check_val("t1 start_addr", 32'(o_start_addr), 32'd0);
        for (int a = 0; a < DEPTH; a++) ev[a] = a;
        read_all("t1", ev);

        // 2: decimation by 3
        start_run(1'b0, 2);
        for (int i = 0; i < 48; i++) begin
            drive(i, 1'b1, 1'b0, 1'b0);
            if (i == 44) check_status("t2 k44", 1'b0, 1'b1);
            if (i == 45) check_status("t2 k45", 1'b1, 1'b0);
        end
        for (int a = 0; a < DEPTH; a++) ev[a] = 3 * a;
        read_all("t2", ev);

        // 3: circular, trigger at k=30
        start_run(1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            drive(i, 1'b1, (i == 30), 1'b0);
            if (i == 36) check_status("t3 k36", 1'b0, 1'b1);
            if (i == 37) check_status("t3 k37", 1'b1, 1'b0);
        end
        check_val("t3 start_addr", 32'(o_start_addr), 32'd6);
        for (int a = 0; a < DEPTH; a++) ev[a] = 22 + a;
        read_all("t3", ev);

        // 4: one-shot with random valid gaps
        start_run(1'b0, 0);
        k = 0;
        cyc = 0;
        while (k < DEPTH && cyc < 400) begin
            check_status("t4 running", 1'b0, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                drive(k, 1'b1, 1'b0, 1'b0);
                k++;
            end else begin
                drive(16'h0A00 + cyc, 1'b0, 1'b0, 1'b0);
            end
            cyc++;
        end
        check_val("t4 samples fed", 32'(k), 32'(DEPTH));
        check_status("t4 done", 1'b1, 1'b0);
        for (int a = 0; a < DEPTH; a++) ev[a] = a;
        read_all("t4", ev);

        // 5: priority and ignored requests
        start_run(1'b0, 0);
        for (int i = 0; i < DEPTH; i++) drive(16'h80 + i, 1'b1, 1'b0, 1'b0);
        check_status("t5 pre", 1'b1, 1'b0);
        i_mode = 1'b1; i_decim = '0; i_run_log = 1'b1; i_read_log = 1'b1;
        @(negedge clk);
        i_run_log = 1'b0; i_read_log = 1'b0;
        check_status("t5 run wins", 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            drive(i, 1'b1, (i == 30) || (i == 33), (i == 5));
            if (i == 5) check_status("t5 read ignored", 1'b0, 1'b1);
            if (i == 36) check_status("t5 k36", 1'b0, 1'b1);
            if (i == 37) check_status("t5 k37", 1'b1, 1'b0);
        end
        check_val("t5 start_addr", 32'(o_start_addr), 32'd6);
        for (int a = 0; a < DEPTH; a++) ev[a] = 22 + a;
        read_all("t5", ev);

        // 6: reset during a one-shot capture at sample 7
        start_run(1'b0, 0);
        for (int i = 0; i < 7; i++) drive(16'h200 + i, 1'b1, 1'b0, 1'b0);
        i_rst = 1'b0;
        drive(16'h207, 1'b1, 1'b0, 1'b0);
        i_rst = 1'b1;
        check_status("t6 reset", 1'b0, 1'b0);
        check_val("t6 start_addr", 32'(o_start_addr), 32'd0);
        check_val("t6 dvalid", 32'(o_data_valid), 32'd0);
        check_val("t6 data", 32'(o_data_log_from_mem), 32'd0);
        // Slots 0..6 hold the aborted capture, 7..15 keep the circular run above
        for (int a = 0; a < DEPTH; a++) ev[a] = (a < 7) ? 16'h200 + a : a + 16;
        read_all("t6 aborted", ev);
        start_run(1'b0, 0);
        for (int i = 0; i < DEPTH; i++) drive(16'h40 + i, 1'b1, 1'b0, 1'b0);
        check_status("t6 rerun", 1'b1, 1'b0);
        check_val("t6 rerun start_addr", 32'(o_start_addr), 32'd0);
        for (int a = 0; a < DEPTH; a++) ev[a] = 16'h40 + a;
        read_all("t6 rerun", ev);

        check_val("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
